// File: rtl/fp_minmax_stream.sv
// fp_minmax_stream: streaming min/max reduction over frames of Len raw
// floating-point samples. It reports the frame maximum and minimum together
// with the index of the first sample holding each value.
// Optional build macro FPMM_NAN_SKIP_EN: NaN samples still count toward Len
// but are left out of the comparison. A frame made only of NaNs reports the
// canonical qNaN with both indices at 0.
//
// Handshake rules, for both ports:
// - A beat transfers on a rising clk edge where valid && ready.
// - in_ready is high in IDLE and ACCUM.
// - out_valid is high only in DONE, and the result holds there until out_ready.
module fp_minmax_stream #(
  parameter int Bits = 16,
  parameter int ExpW = 5,
  parameter int Len  = 8,
  localparam int IdxW = (Len > 1) ? $clog2(Len) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Bits-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [Bits-1:0] max_val,
  output logic [Bits-1:0] min_val,
  output logic [IdxW-1:0] max_idx,
  output logic [IdxW-1:0] min_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      dbg_state
);

  localparam int CntW = $clog2(Len + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [Bits-1:0] QNAN =
    {1'b0, {ExpW{1'b1}}, 1'b1, {(Bits-ExpW-2){1'b0}}};

  logic [1:0]      r_state;
  logic [CntW-1:0] r_cnt;
  logic [Bits-1:0] r_max_val;
  logic [Bits-1:0] r_min_val;
  logic [IdxW-1:0] r_max_idx;
  logic [IdxW-1:0] r_min_idx;
  logic            r_have;
  logic            w_accept;
  logic            w_nan;
  logic            w_last;

  // Strict "a is greater than b" on raw sign/magnitude bits.
  // This puts +0 above -0, and equal bit patterns are never greater.
  function automatic logic f_gt(input logic [Bits-1:0] a, input logic [Bits-1:0] b);
    if (a[Bits-1] != b[Bits-1])
      return ~a[Bits-1];
    else if (!a[Bits-1])
      return a[Bits-2:0] > b[Bits-2:0];
    else
      return a[Bits-2:0] < b[Bits-2:0];
  endfunction

  assign w_accept = in_valid && (r_state != S_DONE);
  assign w_last   = (r_cnt == CntW'(Len - 1));

`ifdef FPMM_NAN_SKIP_EN
  assign w_nan = (&in_data[Bits-2 -: ExpW]) && (|in_data[Bits-ExpW-2:0]);
`else
  assign w_nan = 1'b0;
`endif

  // Frame sequencing and tracker update.
  // r_have marks that a comparable (non-NaN) sample has initialised the trackers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_max_val <= '0;
      r_min_val <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
      r_have    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= CntW'(1);
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_max_val <= w_nan ? QNAN : in_data;
            r_min_val <= w_nan ? QNAN : in_data;
            r_have    <= ~w_nan;
            r_state   <= (Len == 1) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CntW'(1);
            if (!w_nan) begin
              if (!r_have) begin
                r_max_val <= in_data;
                r_min_val <= in_data;
                r_max_idx <= r_cnt[IdxW-1:0];
                r_min_idx <= r_cnt[IdxW-1:0];
                r_have    <= 1'b1;
              end else begin
                if (f_gt(in_data, r_max_val)) begin
                  r_max_val <= in_data;
                  r_max_idx <= r_cnt[IdxW-1:0];
                end
                if (f_gt(r_min_val, in_data)) begin
                  r_min_val <= in_data;
                  r_min_idx <= r_cnt[IdxW-1:0];
                end
              end
            end
            if (w_last)
              r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state != S_DONE);
  assign out_valid = (r_state == S_DONE);
  assign max_val   = r_max_val;
  assign min_val   = r_min_val;
  assign max_idx   = r_max_idx;
  assign min_idx   = r_min_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_minmax_stream.sv
// tb_fp_minmax_stream: bench for fp_minmax_stream at Bits=16, Len=4.
// Runs directed frames, back-pressure, a mid-frame reset and random frames.
// Expected results come from an order-key reference model.
// Build with FPMM_NAN_SKIP_EN defined to cover the NaN-skip variant.
module tb_fp_minmax_stream;

  localparam int W = 36;
  typedef logic [15:0] frame_t [4];

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] max_val;
  logic [15:0] min_val;
  logic [1:0]  max_idx;
  logic [1:0]  min_idx;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  fp_minmax_stream #(.Bits(16), .ExpW(5), .Len(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .max_val(max_val), .min_val(min_val),
    .max_idx(max_idx), .min_idx(min_idx), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: map each value onto a monotone integer key.
  // +0 maps just above -0.
  function automatic int order_key(input logic [15:0] x);
    int mag = int'(x[14:0]);
    return x[15] ? (32767 - mag) : (32768 + mag);
  endfunction

  function automatic bit is_nan(input logic [15:0] x);
`ifdef FPMM_NAN_SKIP_EN
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] model(input frame_t f);
    int bmax = -1;
    int bmin = -1;
    for (int i = 0; i < 4; i++) begin
      if (!is_nan(f[i])) begin
        if (bmax < 0 || order_key(f[i]) > order_key(f[bmax])) bmax = i;
        if (bmin < 0 || order_key(f[i]) < order_key(f[bmin])) bmin = i;
      end
    end
    if (bmax < 0) return {16'h7E00, 16'h7E00, 2'd0, 2'd0};
    return {f[bmax], f[bmin], 2'(bmax), 2'(bmin)};
  endfunction

  // Driver: sends one frame with optional random bubbles and pushes its expectation.
  // Inputs change 1 time unit after a rising edge, and outputs are sampled then.
  task automatic drive_frame(input frame_t f, input logic [W-1:0] expv,
                             input int max_bub, output bit ok);
    bit acc;
    int guard;
    ok = 1'b1;
    exp_q.push_back(expv);
    for (int i = 0; i < 4; i++) begin
      int nb = (max_bub > 0) ? int'($urandom_range(0, max_bub)) : 0;
      repeat (nb) begin
        in_valid = 1'b0;
        in_data = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data = f[i];
      guard = 0;
      do begin
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) ok = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(3);
    checks++;
    if ({out_valid, in_ready, max_val, min_val, max_idx, min_idx, dbg_state} !== {1'b0, 1'b1, 38'd0}) begin
      failures++;
      $display("FAIL reset_state: got ov=%b ir=%b max=%h min=%h mi=%0d ni=%0d st=%0d, want ov=0 ir=1 all zero",
               out_valid, in_ready, max_val, min_val, max_idx, min_idx, dbg_state);
    end
  endtask

  // Directed frames with out_ready held high, so the result lasts one cycle.
  task automatic test_directed;
    frame_t fr [4];
    logic [W-1:0] ev [4];
    logic [W-1:0] e;
    logic [W-1:0] obs;
    bit ok;
    fr[0] = '{16'hC000, 16'h3C00, 16'hB800, 16'h4200};
    ev[0] = {16'h4200, 16'hC000, 2'd3, 2'd0};
    fr[1] = '{16'h0000, 16'h8000, 16'h0000, 16'h8000};
    ev[1] = {16'h0000, 16'h8000, 2'd0, 2'd1};
    fr[2] = '{16'h7E00, 16'h3C00, 16'h7E00, 16'hBC00};
    fr[3] = '{16'h7C01, 16'h7C01, 16'h7C01, 16'h7C01};
`ifdef FPMM_NAN_SKIP_EN
    ev[2] = {16'h3C00, 16'hBC00, 2'd1, 2'd3};
    ev[3] = {16'h7E00, 16'h7E00, 2'd0, 2'd0};
`else
    ev[2] = {16'h7E00, 16'hBC00, 2'd0, 2'd3};
    ev[3] = {16'h7C01, 16'h7C01, 2'd0, 2'd0};
`endif
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1;
      drive_frame(fr[k], ev[k], 0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL directed%0d_accept: timed out waiting for in_ready", k); end
      e = exp_q.pop_front();
      obs = {max_val, min_val, max_idx, min_idx};
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
        failures++;
        $display("FAIL directed%0d_result: got ov=%b %h, want ov=1 %h", k, out_valid, obs, e);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL directed%0d_release: got ov=%b ir=%b, want ov=0 ir=1", k, out_valid, in_ready);
      end
    end
  endtask

  // Back-pressure: the result must hold while out_ready stays low.
  task automatic test_backpressure;
    frame_t f;
    logic [W-1:0] e;
    logic [W-1:0] obs;
    bit ok;
    f = '{16'hC000, 16'h3C00, 16'hB800, 16'h4200};
    out_ready = 1'b0;
    drive_frame(f, {16'h4200, 16'hC000, 2'd3, 2'd0}, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_accept: timed out waiting for in_ready"); end
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      obs = {max_val, min_val, max_idx, min_idx};
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== e) begin
        failures++;
        $display("FAIL bp_hold%0d: got ov=%b ir=%b %h, want ov=1 ir=0 %h", c, out_valid, in_ready, obs, e);
      end
      in_valid = 1'b1;
      in_data = 16'h7BFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
    f = '{16'h3800, 16'hBC00, 16'h4400, 16'hBC00};
    drive_frame(f, {16'h4400, 16'hBC00, 2'd2, 2'd1}, 0, ok);
    e = exp_q.pop_front();
    obs = {max_val, min_val, max_idx, min_idx};
    checks++;
    if (!ok || out_valid !== 1'b1 || obs !== e) begin
      failures++;
      $display("FAIL bp_next_frame: got ok=%b ov=%b %h, want ok=1 ov=1 %h", ok, out_valid, obs, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reset mid-frame: the partial frame must produce no result.
  task automatic test_reset_midframe;
    frame_t f;
    logic [W-1:0] e;
    logic [W-1:0] obs;
    bit ok;
    int seen;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = (i == 0) ? 16'h5000 : 16'hD000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_reset(1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || max_val !== 16'h0 || min_val !== 16'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL midreset_state: got ov=%b ir=%b max=%h min=%h st=%0d, want 0 1 0000 0000 0",
               out_valid, in_ready, max_val, min_val, dbg_state);
    end
    f = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    drive_frame(f, {16'h3C00, 16'h3C00, 2'd0, 2'd0}, 0, ok);
    e = exp_q.pop_front();
    obs = {max_val, min_val, max_idx, min_idx};
    checks++;
    if (!ok || out_valid !== 1'b1 || obs !== e) begin
      failures++;
      $display("FAIL midreset_frame: got ok=%b ov=%b %h, want ok=1 ov=1 %h", ok, out_valid, obs, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    seen = 0;
    repeat (6) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midreset_extra: got %0d extra out_valid cycles, want 0", seen);
    end
  endtask

  // Random frames with bubbles and random consumer delay, checked against the model.
  task automatic test_random;
    logic [15:0] pool [10];
    frame_t f;
    logic [W-1:0] e;
    logic [W-1:0] obs;
    bit ok;
    int dly;
    int lat;
    pool = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h7C00,
             16'hFC00, 16'h7E00, 16'h7C01, 16'hFE00, 16'h0001};
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++)
        f[i] = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 9)] : 16'($urandom);
      if (n % 5 == 4) f = '{pool[7], pool[8], pool[7], pool[8]};
      out_ready = 1'b0;
      drive_frame(f, model(f), 3, ok);
      e = exp_q.pop_front();
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      obs = {max_val, min_val, max_idx, min_idx};
      checks++;
      if (!ok || lat != 0 || obs !== e) begin
        failures++;
        $display("FAIL random%0d: got ok=%b lat=%0d %h, want ok=1 lat=0 %h (frame %h %h %h %h)",
                 n, ok, lat, obs, e, f[0], f[1], f[2], f[3]);
      end
      dly = $urandom_range(0, 3);
      repeat (dly) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
